// File: rtl/mul_unit_ctrl.sv
// Issue/return controller for the 32x32 multiplier unit: round-robin issue, X stage, in-order CDB result queue.
// Optional macro MUL_SIGNED_EN: two's-complement operands (magnitudes to the array, product re-signed before queueing).
module mul_unit_ctrl #(
    parameter int NUM_RS = 3,
    parameter int TAG_W  = 4,
    parameter int QD     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    input  logic [NUM_RS*32-1:0]    rs_a,
    input  logic [NUM_RS*32-1:0]    rs_b,
    output logic [NUM_RS-1:0]       rs_gnt,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic [63:0]             mul_p,
    output logic                    cdb_req,
    input  logic                    cdb_gnt,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [63:0]             cdb_data
);
    localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int QW = (QD > 1) ? $clog2(QD) : 1;
    localparam int CW = $clog2(QD + 1);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW:0]      idx_w;
    logic             found;
    logic             accept;
    logic             pop;
    logic             push;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    q_cnt;
    logic [QW-1:0]    rd_ptr;
    logic [QW-1:0]    wr_ptr;
    logic [TAG_W-1:0] q_tag  [QD];
    logic [63:0]      q_data [QD];
    logic             x_vld;
    logic [TAG_W-1:0] x_tag;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [63:0]      wr_data;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(QD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_w = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            idx_w = {1'b0, ptr} + (PW+1)'(i);
            if (idx_w >= (PW+1)'(NUM_RS)) begin
                idx_w = idx_w - (PW+1)'(NUM_RS);
            end
            if (!found && rs_req[idx_w[PW-1:0]]) begin
                found = 1'b1;
                win   = idx_w[PW-1:0];
            end
        end
    end

    assign accept  = found && (cnt < CW'(QD)) && !rst;
    assign rs_gnt  = accept ? (NUM_RS'(1) << win) : '0;
    assign sel_tag = rs_tag[int'(win)*TAG_W +: TAG_W];
    assign sel_a   = rs_a[int'(win)*32 +: 32];
    assign sel_b   = rs_b[int'(win)*32 +: 32];

    assign cdb_req  = (q_cnt != '0);
    assign cdb_tag  = q_tag[rd_ptr];
    assign cdb_data = q_data[rd_ptr];
    assign pop      = cdb_req && cdb_gnt;
    assign push     = x_vld;

`ifdef MUL_SIGNED_EN
    logic x_neg;

    assign op_a    = sel_a[31] ? (32'd0 - sel_a) : sel_a;
    assign op_b    = sel_b[31] ? (32'd0 - sel_b) : sel_b;
    assign wr_data = x_neg ? (64'd0 - mul_p) : mul_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_neg <= 1'b0;
        end else if (accept) begin
            x_neg <= sel_a[31] ^ sel_b[31];
        end
    end
`else
    assign op_a    = sel_a;
    assign op_b    = sel_b;
    assign wr_data = mul_p;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_vld <= 1'b0;
            x_tag <= '0;
            mul_a <= '0;
            mul_b <= '0;
            ptr   <= '0;
        end else begin
            x_vld <= accept;
            if (accept) begin
                x_tag <= sel_tag;
                mul_a <= op_a;
                mul_b <= op_b;
                ptr   <= (win == PW'(NUM_RS - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Credits cover the X stage plus queued results, so a push never finds the queue full without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (!accept && pop) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
            for (int i = 0; i < QD; i++) begin
                q_tag[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (push) begin
                q_tag[wr_ptr]  <= x_tag;
                q_data[wr_ptr] <= wr_data;
                wr_ptr         <= q_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= q_next(rd_ptr);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + 1'b1;
            end else if (!push && pop) begin
                q_cnt <= q_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Self-checking bench for mul_unit_ctrl: scoreboard of accepted ops, checked against CDB broadcasts.
// Expected products follow MUL_SIGNED_EN when it is defined.
module tb_mul_unit_ctrl;
    localparam int NUM_RS = 3;
    localparam int TAG_W  = 4;
    localparam int QD     = 4;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
        int               cyc;
    } sb_t;

    logic                    clk;
    logic                    rst;
    logic [NUM_RS-1:0]       rs_req;
    logic [NUM_RS*TAG_W-1:0] rs_tag;
    logic [NUM_RS*32-1:0]    rs_a;
    logic [NUM_RS*32-1:0]    rs_b;
    logic [NUM_RS-1:0]       rs_gnt;
    logic [31:0]             mul_a;
    logic [31:0]             mul_b;
    logic [63:0]             mul_p;
    logic                    cdb_req;
    logic                    cdb_gnt;
    logic [TAG_W-1:0]        cdb_tag;
    logic [63:0]             cdb_data;

    sb_t               sb[$];
    sb_t               entry;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                m_ptr   = 0;
    int                win;
    logic              enabled  = 1'b0;
    logic              post_rst = 1'b0;
    logic              head_rdy;
    logic [NUM_RS-1:0] exp_gnt;

    mul_unit_ctrl #(
        .NUM_RS(NUM_RS),
        .TAG_W (TAG_W),
        .QD    (QD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rs_req  (rs_req),
        .rs_tag  (rs_tag),
        .rs_a    (rs_a),
        .rs_b    (rs_b),
        .rs_gnt  (rs_gnt),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p),
        .cdb_req (cdb_req),
        .cdb_gnt (cdb_gnt),
        .cdb_tag (cdb_tag),
        .cdb_data(cdb_data)
    );

    // Behavioural stand-in for the combinational Wallace-tree array.
    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] expProduct(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
        longint sa;
        longint sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        return 64'(sa * sbv);
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic randomizeOperands();
        for (int i = 0; i < NUM_RS; i++) begin
            rs_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom);
            rs_a[i*32 +: 32]         = pickOperand();
            rs_b[i*32 +: 32]         = pickOperand();
        end
    endtask

    task automatic stepCycle(input logic [NUM_RS-1:0] req, input logic gnt, input logic r);
        rs_req  = req;
        cdb_gnt = gnt;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_RS-1:0] req, input logic gnt, input logic r);
        randomizeOperands();
        stepCycle(req, gnt, r);
    endtask

    task automatic driveOp(input int st, input logic [TAG_W-1:0] tag,
                           input logic [31:0] a, input logic [31:0] b);
        randomizeOperands();
        rs_tag[st*TAG_W +: TAG_W] = tag;
        rs_a[st*32 +: 32]         = a;
        rs_b[st*32 +: 32]         = b;
        stepCycle(NUM_RS'(1) << st, 1'b1, 1'b0);
    endtask

    task automatic drainAll();
        repeat (QD + 4) applyStimulus('0, 1'b1, 1'b0);
    endtask

    // Reference: an accepted op is broadcastable two cycles later; credits equal scoreboard occupancy.
    always @(negedge clk) begin
        if (enabled) begin
            exp_gnt = '0;
            win     = -1;
            if (!rst && sb.size() < QD) begin
                for (int i = 0; i < NUM_RS; i++) begin
                    if (win < 0 && rs_req[(m_ptr + i) % NUM_RS]) begin
                        win = (m_ptr + i) % NUM_RS;
                    end
                end
            end
            if (win >= 0) exp_gnt[win] = 1'b1;
            checkOutput("rs_gnt", 64'(rs_gnt), 64'(exp_gnt));

            head_rdy = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
            checkOutput("cdb_req", 64'(cdb_req), 64'(head_rdy));
            if (head_rdy) begin
                checkOutput("cdb_tag", 64'(cdb_tag), 64'(sb[0].tag));
                checkOutput("cdb_data", cdb_data, sb[0].data);
            end

            if (post_rst && !rst) begin
                checkOutput("rst_cdb_tag", 64'(cdb_tag), 64'd0);
                checkOutput("rst_cdb_data", cdb_data, 64'd0);
                checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
                checkOutput("rst_mul_b", 64'(mul_b), 64'd0);
                post_rst = 1'b0;
            end

            if (rst) begin
                sb.delete();
                m_ptr    = 0;
                post_rst = 1'b1;
            end else begin
                if (head_rdy && cdb_gnt) void'(sb.pop_front());
                if (win >= 0) begin
                    entry.tag  = rs_tag[win*TAG_W +: TAG_W];
                    entry.data = expProduct(rs_a[win*32 +: 32], rs_b[win*32 +: 32]);
                    entry.cyc  = cyc;
                    sb.push_back(entry);
                    m_ptr = (win + 1) % NUM_RS;
                end
            end
        end
        cyc++;
    end

    initial begin
        rs_req  = '0;
        rs_tag  = '0;
        rs_a    = '0;
        rs_b    = '0;
        cdb_gnt = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        enabled = 1'b1;
        applyStimulus('0, 1'b0, 1'b1);

        // Single op: station 1, 7 x 6, tag 5.
        driveOp(1, 4'd5, 32'd7, 32'd6);
        drainAll();

        // Round-robin from reset with all stations requesting.
        applyStimulus('0, 1'b1, 1'b1);
        repeat (6) applyStimulus('1, 1'b1, 1'b0);
        drainAll();

        // Backpressure: queue fills, then drains in accept order.
        repeat (6) applyStimulus('1, 1'b0, 1'b0);
        repeat (5) applyStimulus('1, 1'b1, 1'b0);
        drainAll();

        // Three queued plus one in X, then a grant: simultaneous push and pop at the edge.
        repeat (4) applyStimulus('1, 1'b0, 1'b0);
        repeat (3) applyStimulus('1, 1'b1, 1'b0);
        drainAll();

        // Sign handling corners.
        driveOp(0, 4'hA, 32'hFFFF_FFFD, 32'd5);
        driveOp(2, 4'h3, 32'h8000_0000, 32'hFFFF_FFFF);
        driveOp(1, 4'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drainAll();

        // Reset mid-operation, then all stations request.
        repeat (4) applyStimulus('1, 1'b0, 1'b0);
        applyStimulus('1, 1'b0, 1'b1);
        repeat (3) applyStimulus('1, 1'b1, 1'b0);
        drainAll();

        // Random requests and grants.
        for (int k = 0; k < 60; k++) begin
            applyStimulus(NUM_RS'($urandom), ($urandom_range(0, 2) != 0), 1'b0);
        end
        drainAll();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_unit_ctrl.md
# mul_unit_ctrl

Issue/return controller for the 32x32 Wallace-tree multiplier functional unit in the Tomasulo core. Arbitrates round-robin among the multiply reservation stations and registers the winning operands onto the combinational multiplier. Captures each 64-bit product into an in-order result queue and broadcasts it, tagged, on the common data bus (CDB) under a request/grant handshake, with credit-based backpressure to the reservation stations.

## Interface
Parameters:
- NUM_RS, 3: number of requesting reservation stations (2..8)
- TAG_W, 4: reservation-station tag width
- QD, 4: result-queue depth; maximum operations in flight (2..8)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rs_req  in  NUM_RS  per-station request, operands valid
- rs_tag  in  NUM_RS*TAG_W  per-station tag, station i at [i*TAG_W +: TAG_W]
- rs_a  in  NUM_RS*32  per-station operand A, station i at [i*32 +: 32]
- rs_b  in  NUM_RS*32  per-station operand B
- rs_gnt  out  NUM_RS  one-hot accept, combinational, same cycle as rs_req
- mul_a  out  32  registered operand to multiplier array
- mul_b  out  32  registered operand to multiplier array
- mul_p  in  64  combinational product from multiplier array
- cdb_req  out  1  result pending at queue head
- cdb_gnt  in  1  CDB grant, head consumed this cycle
- cdb_tag  out  TAG_W  tag of head result
- cdb_data  out  64  product of head result

## Operation
- cnt: operations accepted but not yet granted on CDB, counting the X stage plus queue entries, range 0..QD.
- Accept condition: `cnt < QD` and at least one rs_req is set. No same-cycle bypass of a CDB pop into the credit check.
- Round-robin: the search starts at `ptr`, and the first requesting index at or after ptr (wrapping) wins. On accept, ptr becomes winner+1 mod NUM_RS.
- rs_gnt is all zero when no accept occurs or when rst=1.
- X stage: on accept, captures operands, tag and x_vld=1. If nothing is accepted, x_vld=0 and mul_a/mul_b hold their previous values.
- Queue write: when x_vld=1, {tag, mul_p} is pushed at the next edge. The queue is in-order FIFO.
- CDB handshake:
  - cdb_req = queue not empty.
  - cdb_tag and cdb_data show the head entry and stay stable until granted.
  - cdb_req && cdb_gnt pops the head at the edge.
  - cdb_gnt with cdb_req=0 is ignored.
- cnt update:
  - +1 on accept, −1 on pop.
  - Both in the same cycle leave cnt unchanged.
  - A push and a pop of the queue in the same cycle are legal at any occupancy, including full.
- Overflow cannot occur by construction, because X plus the queue never exceeds QD.
- Reset values:
  - cnt=0, x_vld=0, queue empty, ptr=0.
  - mul_a=0, mul_b=0, rs_gnt=0.
  - cdb_req=0, cdb_tag=0, cdb_data=0 (head storage cleared).
- Reset mid-operation discards all in-flight and queued results. Reservation stations must reissue.

## Timing
- Cycle t: rs_gnt asserted and operands sampled at the edge ending t.
- t+1: x_vld=1, mul_a/mul_b valid, product settles through the array within the cycle.
- t+2: the entry is in the queue. If the queue was empty, cdb_req=1 with this result.
- Latency from accept to first possible CDB grant: 2 cycles.
- Throughput is 1 per cycle while cdb_gnt is held high (steady-state cnt=2).
- Per cycle: at most 1 accept and 1 pop.

## Configuration
- MUL_SIGNED_EN defined:
  - Operands are two's complement. X stage holds |A|, |B| and neg = A[31]^B[31].
  - The 64-bit product is negated before the queue write when neg=1.
  - The extra logic adds no cycles of latency.
- MUL_SIGNED_EN undefined:
  - Operands are unsigned. mul_a/mul_b are the raw operands and mul_p is written unmodified.

## Test plan
- Single op: station 1 issues 7×6 with tag 5 at cycle t, cdb_gnt=1 → rs_gnt=3'b010 at t; cdb_req=1 with tag 5 and data 42 at t+2; cnt returns to 0.
- Round-robin: all three stations request continuously from reset → grants in order 0,1,2,0; one per cycle; CDB tags return in the same order.
- Backpressure: cdb_gnt=0, 6 requests → exactly 4 accepted, then rs_gnt=0. After cdb_gnt=1, the 4 results drain in accept order, and accepts resume 1 cycle after the first pop.
- Full-queue simultaneous push/pop: queue holds 3 with x_vld=1 and cdb_gnt=1 → pop head and push X in the same edge, no loss, FIFO order intact.
- Signedness: A=0xFFFF_FFFD, B=5 → cdb_data 0xFFFF_FFFF_FFFF_FFF1 with MUL_SIGNED_EN; 0x0000_0004_FFFF_FFF1 without.
- Reset mid-operation: rst pulsed with 3 results queued and one in X → next cycle cdb_req=0, cdb_tag=0, cdb_data=0, cnt=0. The first post-reset request goes to station 0.
